// File: rtl/game_state_controller_if.sv
// ---------------------------------------------------------------------------
// game_state_controller_if
//   Groups the signals between game_state_controller and the rest of
//   top_level: the two raw board keys, the countdown_timer/display_timer
//   handshake, and the round status outputs.
//   master : the controller side (keys and timer status in, control out)
//   slave  : the surrounding logic (keys and timer status out, control in)
//
//   start_btn         raw start key, active-low, asynchronous to clk
//   pause_btn         raw pause/resume key, active-low, asynchronous to clk
//   one_second_pulse  1-cycle tick from countdown_timer
//   game_finished     level from display_timer: count has reached zero
//   timer_load        1-cycle pulse: reload timer/display to start value
//   timer_run         level: gates one_second_pulse into display_timer
//   game_active       high in RUNNING or PAUSED
//   game_over         high in FINISHED
//   blink             toggles per one_second_pulse in FINISHED, else 0
//   state             IDLE=0, RUNNING=1, PAUSED=2, FINISHED=3
// ---------------------------------------------------------------------------
interface game_state_controller_if;
  logic       start_btn;
  logic       pause_btn;
  logic       one_second_pulse;
  logic       game_finished;
  logic       timer_load;
  logic       timer_run;
  logic       game_active;
  logic       game_over;
  logic       blink;
  logic [1:0] state;

  modport master (
    input  start_btn, pause_btn, one_second_pulse, game_finished,
    output timer_load, timer_run, game_active, game_over, blink, state
  );

  modport slave (
    output start_btn, pause_btn, one_second_pulse, game_finished,
    input  timer_load, timer_run, game_active, game_over, blink, state
  );
endinterface

// File: rtl/game_state_controller.sv
// ---------------------------------------------------------------------------
// game_state_controller
//   Round-level control FSM for the countdown game. Synchronises and
//   debounces the start and pause keys, drives the countdown timer's
//   reload pulse and run gate, reacts to game_finished, and holds a
//   blinking game-over phase for FINISH_HOLD_S seconds before idling.
//
//   clk   system clock (50 MHz)
//   rst   asynchronous, active-low reset
//   bus   game_state_controller_if.master (keys, timer handshake, status)
//
//   Parameters:
//   DEBOUNCE_CYCLES  stable cycles before a key level is accepted
//   FINISH_HOLD_S    one_second_pulse count spent in FINISHED (>= 1)
//   DB_W             debounce counter width, must hold DEBOUNCE_CYCLES-1
// ---------------------------------------------------------------------------
module game_state_controller #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int FINISH_HOLD_S   = 5,
  parameter int DB_W            = 19
) (
  input  logic                      clk,
  input  logic                      rst,
  game_state_controller_if.master   bus
);

  localparam int HOLD_W = $clog2(FINISH_HOLD_S + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FINISH_HOLD_S);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUNNING  = 2'd1,
    PAUSED   = 2'd2,
    FINISHED = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Key conditioning. Bit 0 = start key, bit 1 = pause key. Everything
  // resets to the released level (1) so reset release never fakes a press.
  // -------------------------------------------------------------------------
  logic [1:0]      key_raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      db_level_q, db_prev_q;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [1:0]      press_evt;
  logic            start_evt, pause_evt;

  assign key_raw = {bus.pause_btn, bus.start_btn};

  // NOTE: the small counter array is reset element by element; it is two
  // registers, not a RAM, so an async reset costs nothing and keeps the
  // debouncers in a known state after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      db_level_q <= '1;
      db_prev_q  <= '1;
      for (int k = 0; k < 2; k++) db_cnt_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, so sync1 -> sync2 really is two stages and not a wire.
      sync1_q   <= key_raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_level_q;
      for (int k = 0; k < 2; k++) begin
        if (sync2_q[k] == db_level_q[k]) begin
          db_cnt_q[k] <= '0;              // agreement (or a bounce back) restarts
        end else if (db_cnt_q[k] == DB_LAST) begin
          db_level_q[k] <= sync2_q[k];    // differed for DEBOUNCE_CYCLES cycles
          db_cnt_q[k]   <= '0;
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // Falling edge of the debounced level only: releases never produce events.
  assign press_evt = db_prev_q & ~db_level_q;
  assign start_evt = press_evt[0];
  assign pause_evt = press_evt[1];

  // -------------------------------------------------------------------------
  // Round FSM
  // -------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic                load_q, load_d;
  logic                run_q;
  logic                blink_q, blink_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  // NOTE: every variable gets a default before the case statement so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    hold_d  = '0;
    blink_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_evt) begin
          state_d = RUNNING;
          load_d  = 1'b1;
        end
      end
      RUNNING: begin
        if (bus.game_finished) state_d = FINISHED;
        else if (start_evt)    load_d  = 1'b1;     // restart in place
        else if (pause_evt)    state_d = PAUSED;
      end
      PAUSED: begin
        if (start_evt) begin
          state_d = RUNNING;
          load_d  = 1'b1;
        end else if (pause_evt) begin
          state_d = RUNNING;
        end
      end
      FINISHED: begin
        if (start_evt) begin
          state_d = RUNNING;
          load_d  = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // hold_cnt/blink live only while staying in FINISHED: entry and exit
    // both see the zero defaults. Staying implies hold_q < HOLD_LAST, so
    // the increment can never wrap.
    if (state_q == FINISHED && state_d == FINISHED) begin
      hold_d  = hold_q;
      blink_d = blink_q;
      if (bus.one_second_pulse) begin
        hold_d  = hold_q + 1'b1;
        blink_d = ~blink_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      run_q   <= 1'b0;
      blink_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      run_q   <= (state_d == RUNNING);
      blink_q <= blink_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.timer_load  = load_q;
  assign bus.timer_run   = run_q;
  assign bus.blink       = blink_q;
  assign bus.game_active = (state_q == RUNNING) || (state_q == PAUSED);
  assign bus.game_over   = (state_q == FINISHED);

endmodule

// File: tb/tb_game_state_controller.sv
// ---------------------------------------------------------------------------
// tb_game_state_controller
//   Directed bench for game_state_controller with DEBOUNCE_CYCLES=4 and
//   FINISH_HOLD_S=3. A table of {operation, expected outputs, expected
//   timer_load count} records drives the main round flow; hand-written
//   sequences cover bounce rejection, same-cycle priority, start from
//   FINISHED, simultaneous keys and asynchronous reset mid-round.
//   Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_game_state_controller;

  localparam int DB   = 4;
  localparam int HOLD = 3;
  localparam int WIN  = DB + 6;   // press/release window, covers sync + debounce

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  game_state_controller_if bus ();

  game_state_controller #(
    .DEBOUNCE_CYCLES (DB),
    .FINISH_HOLD_S   (HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef enum int {OP_START, OP_PAUSE, OP_PULSE, OP_FIN, OP_WAIT} op_t;

  typedef struct {
    op_t        op;
    logic [1:0] st;
    logic       run;
    logic       act;
    logic       over;
    logic       blk;
    int         loads;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int loads = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // {state, timer_run, game_active, game_over, blink}
  function automatic logic [5:0] outs();
    return {bus.state, bus.timer_run, bus.game_active, bus.game_over, bus.blink};
  endfunction

  // One clock; count timer_load pulses seen on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (bus.timer_load) loads++;
  endtask

  // keys[0] = start, keys[1] = pause. Hold low for WIN cycles, then release
  // for WIN cycles so the debounced level is back high afterwards.
  task automatic press(input logic [1:0] keys);
    if (keys[0]) bus.start_btn = 1'b0;
    if (keys[1]) bus.pause_btn = 1'b0;
    repeat (WIN) tick();
    bus.start_btn = 1'b1;
    bus.pause_btn = 1'b1;
    repeat (WIN) tick();
  endtask

  task automatic sec_pulse();
    bus.one_second_pulse = 1'b1;
    tick();
    bus.one_second_pulse = 1'b0;
  endtask

  task automatic fin_pulse();
    bus.game_finished = 1'b1;
    tick();
    bus.game_finished = 1'b0;
  endtask

  vec_t vecs [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         op        st    run act over blk loads
    vecs[0]  = '{OP_START, 2'd1, 1, 1, 0, 0, 1};   // IDLE -> RUNNING, one load
    vecs[1]  = '{OP_PAUSE, 2'd2, 0, 1, 0, 0, 0};   // pause
    vecs[2]  = '{OP_PAUSE, 2'd1, 1, 1, 0, 0, 0};   // resume, no load
    vecs[3]  = '{OP_START, 2'd1, 1, 1, 0, 0, 1};   // restart in RUNNING
    vecs[4]  = '{OP_PAUSE, 2'd2, 0, 1, 0, 0, 0};
    vecs[5]  = '{OP_FIN,   2'd2, 0, 1, 0, 0, 0};   // finished ignored in PAUSED
    vecs[6]  = '{OP_START, 2'd1, 1, 1, 0, 0, 1};   // start from PAUSED reloads
    vecs[7]  = '{OP_FIN,   2'd3, 0, 0, 1, 0, 0};   // RUNNING -> FINISHED
    vecs[8]  = '{OP_PULSE, 2'd3, 0, 0, 1, 1, 0};   // blink 1
    vecs[9]  = '{OP_PULSE, 2'd3, 0, 0, 1, 0, 0};   // blink 0
    vecs[10] = '{OP_PULSE, 2'd3, 0, 0, 1, 1, 0};   // blink 1, hold full
    vecs[11] = '{OP_WAIT,  2'd0, 0, 0, 0, 0, 0};   // auto-return to IDLE
    vecs[12] = '{OP_PAUSE, 2'd0, 0, 0, 0, 0, 0};   // pause ignored in IDLE
    vecs[13] = '{OP_PULSE, 2'd0, 0, 0, 0, 0, 0};   // no blink in IDLE

    bus.start_btn        = 1'b1;
    bus.pause_btn        = 1'b1;
    bus.one_second_pulse = 1'b0;
    bus.game_finished    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 6'd0);
    check("reset_load", bus.timer_load, 1'b0);
    rst = 1'b1;
    repeat (2) tick();

    // Table-driven round flow
    foreach (vecs[i]) begin
      loads = 0;
      case (vecs[i].op)
        OP_START: press(2'b01);
        OP_PAUSE: press(2'b10);
        OP_PULSE: sec_pulse();
        OP_FIN:   fin_pulse();
        default:  tick();
      endcase
      check($sformatf("vec%0d_outs", i), outs(),
            {vecs[i].st, vecs[i].run, vecs[i].act, vecs[i].over, vecs[i].blk});
      check($sformatf("vec%0d_loads", i), loads, vecs[i].loads);
    end

    // Bounce: low 2, high 1, low 2 never reaches DB stable cycles
    loads = 0;
    bus.start_btn = 1'b0; repeat (2) tick();
    bus.start_btn = 1'b1; tick();
    bus.start_btn = 1'b0; repeat (2) tick();
    bus.start_btn = 1'b1; repeat (WIN) tick();
    check("bounce_state", bus.state, 2'd0);
    check("bounce_loads", loads, 0);

    // Same-cycle game_finished and pause_evt in RUNNING: finished wins.
    // The pause event is seen by the FSM on the (2 + DB + 1)-th edge after
    // the key falls, so game_finished is raised just before that edge.
    press(2'b01);
    check("prio_pre_state", bus.state, 2'd1);
    bus.pause_btn = 1'b0;
    repeat (2 + DB) tick();
    bus.game_finished = 1'b1;
    tick();
    check("prio_state", bus.state, 2'd3);
    check("prio_game_over", bus.game_over, 1'b1);
    bus.game_finished = 1'b0;
    bus.pause_btn = 1'b1;
    repeat (WIN) tick();
    sec_pulse(); check("hold_blink1", bus.blink, 1'b1);
    sec_pulse(); check("hold_blink2", bus.blink, 1'b0);
    sec_pulse(); check("hold_blink3", bus.blink, 1'b1);
    check("hold_state3", bus.state, 2'd3);
    tick();
    check("hold_exit", outs(), 6'd0);

    // Start from FINISHED after one pulse
    press(2'b01);
    fin_pulse();
    sec_pulse();
    check("fin_blink", bus.blink, 1'b1);
    loads = 0;
    press(2'b01);
    check("fin_start_outs", outs(), {2'd1, 1'b1, 1'b1, 1'b0, 1'b0});
    check("fin_start_loads", loads, 1);

    // Start and pause together in PAUSED: start action with reload
    press(2'b10);
    check("both_pre_state", bus.state, 2'd2);
    loads = 0;
    press(2'b11);
    check("both_state", bus.state, 2'd1);
    check("both_loads", loads, 1);

    // Async reset in PAUSED, asserted between clock edges
    press(2'b10);
    check("rst_pre_state", bus.state, 2'd2);
    #2 rst = 1'b0;
    #1;
    check("rst_async_outs", outs(), 6'd0);
    check("rst_async_load", bus.timer_load, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    loads = 0;
    repeat (20) tick();
    check("rst_release_loads", loads, 0);
    check("rst_release_state", bus.state, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
